// File: rtl/stoplight_monitor_pkg.sv
// Shared stoplight definitions: light codes, tracker FSM states and small decode helpers.
// Used by both the stoplight controller and the stoplight monitor.
package stoplight_monitor_pkg;

  localparam logic [2:0] LIGHT_GRN = 3'b100;
  localparam logic [2:0] LIGHT_YLW = 3'b010;
  localparam logic [2:0] LIGHT_RED = 3'b001;

  typedef enum logic [1:0] {
    S_GRN = 2'd0,
    S_YLW = 2'd1,
    S_RED = 2'd2
  } light_state_e;

  typedef struct packed {
    logic onehot;
    logic seq;
    logic yellow;
  } tracker_err_t;

  function automatic logic is_legal_light(input logic [2:0] code);
    return (code == LIGHT_GRN) || (code == LIGHT_YLW) || (code == LIGHT_RED);
  endfunction

  // A light that is letting traffic move (GRN or YLW).
  function automatic logic is_go_light(input logic [2:0] code);
    return (code == LIGHT_GRN) || (code == LIGHT_YLW);
  endfunction

  function automatic light_state_e light_to_state(input logic [2:0] code);
    light_state_e s;
    s = S_RED;
    if (code == LIGHT_GRN) s = S_GRN;
    else if (code == LIGHT_YLW) s = S_YLW;
    return s;
  endfunction

endpackage

// File: rtl/stoplight_monitor_if.sv
// Observation bus of the stoplight monitor: the two lights and car sensor in,
// the error flags and error counter out.
interface stoplight_monitor_if #(
  parameter int CNT_W = 8
);
  logic [2:0]       light_pros;
  logic [2:0]       light_wash;
  logic             car_present;
  logic             err_onehot;
  logic             err_conflict;
  logic             err_sequence;
  logic             err_yellow;
  logic             err_spurious;
  logic             err_any;
  logic [CNT_W-1:0] err_count;

  modport master (
    output light_pros, light_wash, car_present,
    input  err_onehot, err_conflict, err_sequence, err_yellow, err_spurious,
    input  err_any, err_count
  );

  modport slave (
    input  light_pros, light_wash, car_present,
    output err_onehot, err_conflict, err_sequence, err_yellow, err_spurious,
    output err_any, err_count
  );
endinterface

// File: rtl/stoplight_monitor_light_tracker.sv
// Per-light tracker: follows one light through GRN/YLW/RED and reports one-hot,
// transition and yellow-dwell violations for the current sample (unregistered).
module light_tracker
  import stoplight_monitor_pkg::*;
#(
  parameter int YLW_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   light,
  input  logic         first_sample,
  output tracker_err_t err,
  output logic         grn_to_ylw
);

  localparam int DW = $clog2(YLW_CYCLES + 2);
  localparam logic [DW-1:0] DWELL_ONE = 1;
  localparam logic [DW-1:0] DWELL_TGT = YLW_CYCLES[DW-1:0];
  localparam logic [DW-1:0] DWELL_MAX = DW'(YLW_CYCLES + 1);

  light_state_e  state_q, state_d;
  light_state_e  cur;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          skip_q, skip_d;
  logic          legal;
  logic          check_en;

  always_comb begin
    legal      = is_legal_light(light);
    cur        = light_to_state(light);
    check_en   = legal && !skip_q && !first_sample;
    state_d    = state_q;
    dwell_d    = '0;
    skip_d     = !legal;
    err        = '0;
    grn_to_ylw = 1'b0;

    err.onehot = !legal;
    // An illegal code leaves the tracked state alone; the sample after it is not checked.
    if (legal) begin
      state_d = cur;
      if (cur == S_YLW) begin
        if (state_q != S_YLW)       dwell_d = DWELL_ONE;
        else if (dwell_q == DWELL_MAX) dwell_d = dwell_q;
        else                         dwell_d = dwell_q + 1'b1;
      end
    end

    if (check_en) begin
      err.seq    = ((state_q == S_GRN) && (cur == S_RED)) ||
                   ((state_q == S_YLW) && (cur == S_GRN)) ||
                   ((state_q == S_RED) && (cur == S_YLW));
      // Early exit, or the one sample where the dwell first exceeds the target.
      err.yellow = ((state_q == S_YLW) && (cur != S_YLW) && (dwell_q < DWELL_TGT)) ||
                   ((state_q == S_YLW) && (cur == S_YLW) && (dwell_q == DWELL_TGT));
      grn_to_ylw = (state_q == S_GRN) && (cur == S_YLW);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RED;
      dwell_q <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      skip_q  <= skip_d;
    end
  end

endmodule

// File: rtl/stoplight_monitor.sv
// Stoplight monitor top: two light trackers plus conflict, spurious-change and
// error-counting logic; every output is a flop.
module stoplight_monitor
  import stoplight_monitor_pkg::*;
#(
  parameter int YLW_CYCLES = 1,
  parameter int CNT_W      = 8
) (
  input logic                clk,
  input logic                rst,
  stoplight_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // Lights whose GRN->YLW change must be requested by the car sensor (index 1 = Washington).
  localparam logic [1:0] CAR_GATED = 2'b10;

  logic [2:0]   light_in [2];
  tracker_err_t trk_err  [2];
  logic [1:0]   g2y;
  logic         first_sample;
  logic         any_now;

  logic             valid_q, valid_d;
  logic             car_q, car_d;
  logic             err_onehot_q, err_onehot_d;
  logic             err_conflict_q, err_conflict_d;
  logic             err_sequence_q, err_sequence_d;
  logic             err_yellow_q, err_yellow_d;
  logic             err_spurious_q, err_spurious_d;
  logic             err_any_q, err_any_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  assign light_in[0]  = bus.light_pros;
  assign light_in[1]  = bus.light_wash;
  assign first_sample = !valid_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_trk
    light_tracker #(
      .YLW_CYCLES(YLW_CYCLES)
    ) u_trk (
      .clk         (clk),
      .rst         (rst),
      .light       (light_in[gi]),
      .first_sample(first_sample),
      .err         (trk_err[gi]),
      .grn_to_ylw  (g2y[gi])
    );
  end

  always_comb begin
    valid_d        = 1'b1;
    car_d          = bus.car_present;
    err_onehot_d   = trk_err[0].onehot | trk_err[1].onehot;
    err_sequence_d = trk_err[0].seq    | trk_err[1].seq;
    err_yellow_d   = trk_err[0].yellow | trk_err[1].yellow;
    err_conflict_d = is_go_light(bus.light_pros) && is_go_light(bus.light_wash);
    err_spurious_d = valid_q && !car_q && (|(g2y & CAR_GATED));
    any_now        = err_onehot_d | err_sequence_d | err_yellow_d |
                     err_conflict_d | err_spurious_d;
    err_any_d      = err_any_q | any_now;
    err_count_d    = err_count_q;
    if (any_now && (err_count_q != CNT_MAX)) err_count_d = err_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q        <= 1'b0;
      car_q          <= 1'b0;
      err_onehot_q   <= 1'b0;
      err_conflict_q <= 1'b0;
      err_sequence_q <= 1'b0;
      err_yellow_q   <= 1'b0;
      err_spurious_q <= 1'b0;
      err_any_q      <= 1'b0;
      err_count_q    <= '0;
    end else begin
      valid_q        <= valid_d;
      car_q          <= car_d;
      err_onehot_q   <= err_onehot_d;
      err_conflict_q <= err_conflict_d;
      err_sequence_q <= err_sequence_d;
      err_yellow_q   <= err_yellow_d;
      err_spurious_q <= err_spurious_d;
      err_any_q      <= err_any_d;
      err_count_q    <= err_count_d;
    end
  end

  assign bus.err_onehot   = err_onehot_q;
  assign bus.err_conflict = err_conflict_q;
  assign bus.err_sequence = err_sequence_q;
  assign bus.err_yellow   = err_yellow_q;
  assign bus.err_spurious = err_spurious_q;
  assign bus.err_any      = err_any_q;
  assign bus.err_count    = err_count_q;

endmodule

// File: tb/tb_stoplight_monitor.sv
// Scoreboard bench for stoplight_monitor: directed samples push expected flags and
// counts; a monitor pops one entry per clock and compares two DUT instances.
module tb_stoplight_monitor;

  localparam logic [2:0] G = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b001;
  // Flag order: {onehot, conflict, sequence, yellow, spurious}
  localparam logic [4:0] F_NO = 5'b00000;
  localparam logic [4:0] F_OH = 5'b10000;
  localparam logic [4:0] F_CF = 5'b01000;
  localparam logic [4:0] F_SQ = 5'b00100;
  localparam logic [4:0] F_YL = 5'b00010;
  localparam logic [4:0] F_SP = 5'b00001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] pros_r = 3'b001;
  logic [2:0] wash_r = 3'b001;
  logic       car_r = 1'b0;

  always #5 clk = ~clk;

  stoplight_monitor_if #(.CNT_W(8)) bus8 ();
  stoplight_monitor_if #(.CNT_W(2)) bus2 ();

  assign bus8.light_pros  = pros_r;
  assign bus8.light_wash  = wash_r;
  assign bus8.car_present = car_r;
  assign bus2.light_pros  = pros_r;
  assign bus2.light_wash  = wash_r;
  assign bus2.car_present = car_r;

  stoplight_monitor #(.YLW_CYCLES(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus8)
  );
  stoplight_monitor #(.YLW_CYCLES(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  typedef struct {
    int         id;
    logic [4:0] flags;
    logic       any;
    logic [7:0] cnt;
    logic [1:0] cnt_sat;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_txn = 0;
  logic [7:0] m_cnt = 8'd0;
  logic [1:0] m_cnt_sat = 2'd0;
  logic       m_any = 1'b0;

  // Drive one sample and record what the outputs must show after the next rising edge.
  task automatic step(input logic r, input logic [2:0] p, input logic [2:0] w,
                      input logic c, input logic [4:0] f);
    exp_t e;
    @(negedge clk);
    rst = r; pros_r = p; wash_r = w; car_r = c;
    if (!r) begin
      m_cnt = 8'd0; m_cnt_sat = 2'd0; m_any = 1'b0; e.flags = F_NO;
    end else begin
      e.flags = f;
      if (f != F_NO) begin
        m_any = 1'b1;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        if (m_cnt_sat != 2'd3) m_cnt_sat = m_cnt_sat + 2'd1;
      end
    end
    e.id = n_txn; e.any = m_any; e.cnt = m_cnt; e.cnt_sat = m_cnt_sat;
    n_txn++;
    sb_q.push_back(e);
  endtask

  task automatic check(input string name, input int id, input logic [7:0] act,
                       input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL txn %0d %s: got %0h, expected %0h", id, name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    logic [4:0] f8, f2;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e  = sb_q.pop_front();
        f8 = {bus8.err_onehot, bus8.err_conflict, bus8.err_sequence,
              bus8.err_yellow, bus8.err_spurious};
        f2 = {bus2.err_onehot, bus2.err_conflict, bus2.err_sequence,
              bus2.err_yellow, bus2.err_spurious};
        check("flags",     e.id, {3'b000, f8}, {3'b000, e.flags});
        check("flags_sat", e.id, {3'b000, f2}, {3'b000, e.flags});
        check("err_any",   e.id, {7'd0, bus8.err_any}, {7'd0, e.any});
        check("err_count", e.id, bus8.err_count, e.cnt);
        check("count_sat", e.id, {6'd0, bus2.err_count}, {6'd0, e.cnt_sat});
        $display("txn %0d: rst=%b pros=%b wash=%b flags=%b any=%b cnt=%0d cnt_sat=%0d",
                 e.id, rst, pros_r, wash_r, f8, bus8.err_any, bus8.err_count, bus2.err_count);
      end
    end
  end

  initial begin : stimulus
    // Reset state
    step(0, R, R, 0, F_NO);
    step(0, R, R, 0, F_NO);
    // Legal cycle: no flags at all
    repeat (8) step(1, R, G, 0, F_NO);
    step(1, R, G, 1, F_NO);
    step(1, R, Y, 1, F_NO);
    step(1, R, R, 1, F_NO);
    repeat (4) step(1, G, R, 1, F_NO);
    step(1, Y, R, 1, F_NO);
    step(1, R, R, 1, F_NO);
    step(1, R, G, 1, F_NO);
    // Conflict on the very first post-reset sample
    step(0, R, R, 0, F_NO);
    step(1, G, G, 1, F_CF);
    step(0, R, R, 0, F_NO);
    // Bad sequence, then bad one-hot, then the skipped sample
    step(1, R, G, 1, F_NO);
    step(1, R, G, 1, F_NO);
    step(1, R, R, 1, F_SQ);
    step(1, 3'b011, R, 1, F_OH);
    step(1, R, R, 1, F_NO);
    step(1, R, R, 1, F_NO);
    step(0, R, R, 0, F_NO);
    // Over-long yellow: one pulse at the second YLW sample
    step(1, R, G, 1, F_NO);
    step(1, R, Y, 1, F_NO);
    step(1, R, Y, 1, F_YL);
    step(1, R, Y, 1, F_NO);
    step(1, R, R, 1, F_NO);
    step(0, R, R, 0, F_NO);
    // Spurious change, then counter saturation in the 2-bit instance
    step(1, R, G, 0, F_NO);
    step(1, R, G, 0, F_NO);
    step(1, R, Y, 1, F_SP);
    step(1, R, R, 1, F_NO);
    step(1, 3'b000, R, 1, F_OH);
    step(1, 3'b000, R, 1, F_OH);
    repeat (3) step(1, 3'b111, R, 1, F_OH);
    step(1, R, R, 1, F_NO);
    step(1, R, R, 1, F_NO);
    // Two errors in one sample count once
    step(1, 3'b110, Y, 1, F_OH | F_SQ);
    step(1, R, R, 1, F_NO);
    // Reset asserted mid-yellow, released while yellow is still shown
    step(1, R, G, 1, F_NO);
    step(1, R, Y, 1, F_NO);
    step(0, R, Y, 1, F_NO);
    step(0, R, Y, 1, F_NO);
    step(1, R, Y, 1, F_NO);
    step(1, R, R, 1, F_NO);
    step(1, R, G, 1, F_NO);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stoplight_monitor.md
STOPLIGHT_MONITOR -- requirements
Module: stoplight_monitor

Interface
REQ-001 Parameter YLW_CYCLES, default 1: exact number of consecutive samples a light SHALL hold YLW.
REQ-002 Parameter CNT_W, default 8: width of the error counter.
REQ-003 clk  input  1  single clock; all sampling on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 light_pros  input  3  Prospect light under observation; one-hot GRN=100, YLW=010, RED=001.
REQ-006 light_wash  input  3  Washington light under observation; same encoding.
REQ-007 car_present  input  1  same car sensor that drives the stoplight.
REQ-008 err_onehot  output  1  pulse: a light was not a legal one-hot code.
REQ-009 err_conflict  output  1  pulse: both lights were non-RED in the same sample.
REQ-010 err_sequence  output  1  pulse: illegal per-light transition.
REQ-011 err_yellow  output  1  pulse: YLW dwell differed from YLW_CYCLES.
REQ-012 err_spurious  output  1  pulse: Washington left GRN without a car request.
REQ-013 err_any  output  1  sticky OR of all error pulses since reset.
REQ-014 err_count  output  CNT_W  saturating count of samples with at least one error.

Function
REQ-015 The block SHALL sample both lights and car_present on every rising clk edge.
REQ-016 All outputs SHALL be registered; an error pulse SHALL assert for exactly one cycle, in the cycle after the offending sample.
REQ-017 One-hot check: any code other than 100, 010 or 001 on either light SHALL raise err_onehot; that light SHALL then skip the sequence and yellow checks for that sample and the next one.
REQ-018 Conflict check: both lights simultaneously in GRN or YLW SHALL raise err_conflict.
REQ-019 Sequence check: each light tracker SHALL run a three-state FSM (S_GRN, S_YLW, S_RED).
REQ-020 Legal transitions are hold, GRN->YLW, YLW->RED and RED->GRN; GRN->RED, YLW->GRN and RED->YLW SHALL raise err_sequence.
REQ-021 Yellow dwell: each tracker SHALL count consecutive YLW samples.
REQ-022 Leaving YLW after fewer than YLW_CYCLES samples, or holding YLW for more than YLW_CYCLES samples, SHALL raise err_yellow.
REQ-023 An over-long yellow SHALL be flagged once, at sample YLW_CYCLES+1, not on every later sample.
REQ-024 Spurious-change check: a Washington GRN->YLW transition seen at sample n SHALL raise err_spurious if car_present was 0 at sample n-1.
REQ-025 Several simultaneous errors SHALL each pulse their own flag, and SHALL increment err_count by exactly 1.
REQ-026 err_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 err_any SHALL set on any error pulse and clear only on reset.
REQ-028 The first sample after reset release SHALL have no valid predecessor.
REQ-029 On that first sample the sequence, yellow and spurious checks SHALL be suppressed; the one-hot and conflict checks SHALL still apply.

Reset
REQ-030 While rst=0, all error pulses, err_any and err_count SHALL be 0.
REQ-031 While rst=0, both tracker FSMs SHALL be in S_RED with dwell counters at 0 and the predecessor-valid flag cleared.
REQ-032 Reset assertion mid-yellow or mid-error SHALL clear all state immediately, with no pulse after release.

Structure
REQ-033 The GRN/YLW/RED encodings SHALL live in a shared stoplight definitions header; the Stoplight block and this block SHALL both use it.
REQ-034 The FSM state encodings SHALL live in the same shared header.
REQ-035 The per-light FSM, dwell counter, one-hot, sequence and yellow logic SHALL be one sub-module, light_tracker, instantiated twice.
REQ-036 Conflict, spurious and counter logic SHALL live in stoplight_monitor.

Verification
REQ-037 Legal cycle: wash GRN with car=0 for 8 cycles; car=1; wash YLW for 1 cycle, then RED; pros GRN 4 cycles, YLW 1, RED; wash GRN -> no error flags, err_count=0.
REQ-038 Conflict: both lights driven 100 for one sample -> err_conflict pulses once, err_count=1, err_any=1.
REQ-039 Bad sequence and one-hot: wash GRN->RED directly -> err_sequence only; pros=011 -> err_onehot only; err_count=2.
REQ-040 Yellow length: wash YLW held 3 samples (YLW_CYCLES=1) -> single err_yellow pulse at the 2nd YLW sample; err_count=1.
REQ-041 Spurious and saturation: wash GRN->YLW with car=0 on the prior sample -> err_spurious; with CNT_W=2, 5 bad samples -> err_count=3.
REQ-042 Reset mid-yellow: rst=0 during wash YLW, then release -> all outputs 0 and no pulse on the first post-reset sample.
